dram_bank_scheduler: RTL and testbench

Command scheduler between the address/data buffers and the DRAM bank array. It accepts one translated read/write request at a time (bank, row, col) and tracks the open row of every bank (open-page policy). It emits the ACTIVATE / column / PRECHARGE / REFRESH command sequence over the cmd_req/cmd_ack handshake. It also owns the refresh interval counter, so periodic refresh is scheduled between requests.

---
 rtl/dram_bank_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dram_bank_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_scheduler.sv
// Open-page DRAM command scheduler: turns one request at a time into ACT/COL/PRE
// commands and slots periodic all-bank refresh (PRE of every open bank, then REF) between requests.
module dram_bank_scheduler #(
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUM_OF_ROWS      = 128,
    parameter int NUM_OF_COLS      = 8,
    parameter int REFRESH_INTERVAL = 64,
    localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int RW = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1,
    localparam int CW = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    req_val,
    input  logic                    req_rw,
    input  logic [BW-1:0]           req_bank,
    input  logic [RW-1:0]           req_row,
    input  logic [CW-1:0]           req_col,
    output logic                    req_rdy,
    output logic                    cmd_req,
    output logic [1:0]              cmd,
    output logic [BW-1:0]           cmd_bank,
    output logic [RW-1:0]           cmd_row,
    output logic [CW-1:0]           cmd_col,
    output logic                    cmd_rw,
    input  logic                    cmd_ack,
    output logic                    done,
    output logic [NUM_OF_BANKS-1:0] bank_open,
    output logic                    refresh_busy,
    output logic                    refresh_miss
);

    localparam int CNTW = $clog2(REFRESH_INTERVAL);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_PRE = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ACT  = 3'd2,
        S_COL  = 3'd3,
        S_RPRE = 3'd4,
        S_REF  = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic                    rw_reg, rw_next;
    logic [BW-1:0]           bank_reg, bank_next;
    logic [RW-1:0]           row_reg, row_next;
    logic [CW-1:0]           col_reg, col_next;
    logic [NUM_OF_BANKS-1:0] bank_open_reg, bank_open_next;
    logic [CNTW-1:0]         refresh_cnt_reg, refresh_cnt_next;
    logic                    refresh_pending_reg, refresh_pending_next;
    logic                    refresh_miss_reg, refresh_miss_next;
    logic                    open_row_we;
    logic                    ref_done;
    logic                    ack;
    logic                    wrap;
    logic [RW-1:0]           open_row_arr [NUM_OF_BANKS];

    logic                    req_rdy_reg, req_rdy_next;
    logic                    cmd_req_reg, cmd_req_next;
    logic [1:0]              cmd_reg, cmd_next;
    logic [BW-1:0]           cmd_bank_reg, cmd_bank_next;
    logic [RW-1:0]           cmd_row_reg, cmd_row_next;
    logic [CW-1:0]           cmd_col_reg, cmd_col_next;
    logic                    cmd_rw_reg, cmd_rw_next;
    logic                    done_reg, done_next;
    logic                    refresh_busy_reg, refresh_busy_next;

    // An ack only counts while a command is actually being presented.
    assign ack  = cmd_ack && cmd_req_reg;
    assign wrap = (refresh_cnt_reg == CNTW'(REFRESH_INTERVAL - 1));

    function automatic logic [BW-1:0] lowest_open(input logic [NUM_OF_BANKS-1:0] v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
            if (v[i]) r = BW'(i);
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OF_BANKS; gi++) begin : g_bank
            logic [RW-1:0] open_row_reg;
            always_ff @(posedge clk) begin
                if (!rst_b) begin
                    open_row_reg <= '0;
                end else if (open_row_we && (bank_reg == BW'(gi))) begin
                    open_row_reg <= row_reg;
                end
            end
            assign open_row_arr[gi] = open_row_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg           <= S_IDLE;
            rw_reg              <= 1'b0;
            bank_reg            <= '0;
            row_reg             <= '0;
            col_reg             <= '0;
            bank_open_reg       <= '0;
            refresh_cnt_reg     <= '0;
            refresh_pending_reg <= 1'b0;
            refresh_miss_reg    <= 1'b0;
        end else begin
            state_reg           <= state_next;
            rw_reg              <= rw_next;
            bank_reg            <= bank_next;
            row_reg             <= row_next;
            col_reg             <= col_next;
            bank_open_reg       <= bank_open_next;
            refresh_cnt_reg     <= refresh_cnt_next;
            refresh_pending_reg <= refresh_pending_next;
            refresh_miss_reg    <= refresh_miss_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rw_next          = rw_reg;
        bank_next        = bank_reg;
        row_next         = row_reg;
        col_next         = col_reg;
        bank_open_next   = bank_open_reg;
        open_row_we      = 1'b0;
        ref_done         = 1'b0;
        refresh_cnt_next = wrap ? '0 : refresh_cnt_reg + 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (refresh_pending_reg) begin
                    state_next = (|bank_open_reg) ? S_RPRE : S_REF;
                end else if (req_val && req_rdy_reg) begin
                    rw_next   = req_rw;
                    bank_next = req_bank;
                    row_next  = req_row;
                    col_next  = req_col;
                    if (bank_open_reg[req_bank]) begin
                        state_next = (open_row_arr[req_bank] == req_row) ? S_COL : S_PRE;
                    end else begin
                        state_next = S_ACT;
                    end
                end
            end
            S_PRE: begin
                if (ack) begin
                    bank_open_next[bank_reg] = 1'b0;
                    state_next               = S_ACT;
                end
            end
            S_ACT: begin
                if (ack) begin
                    bank_open_next[bank_reg] = 1'b1;
                    open_row_we              = 1'b1;
                    state_next               = S_COL;
                end
            end
            S_COL: begin
                if (ack) state_next = S_IDLE;
            end
            S_RPRE: begin
                // cmd_bank_reg holds the bank whose precharge is being acknowledged.
                if (ack) begin
                    bank_open_next[cmd_bank_reg] = 1'b0;
                    if (bank_open_next == '0) state_next = S_REF;
                end
            end
            S_REF: begin
                if (ack) begin
                    ref_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A wrap coinciding with the REF ack starts a fresh interval rather than a miss.
        refresh_pending_next = refresh_pending_reg && !ref_done;
        refresh_miss_next    = refresh_miss_reg;
        if (wrap) begin
            refresh_pending_next = 1'b1;
            if (refresh_pending_reg && !ref_done) refresh_miss_next = 1'b1;
        end
    end

    always_comb begin
        req_rdy_next      = (state_next == S_IDLE) && !refresh_pending_next;
        cmd_req_next      = (state_next != S_IDLE);
        refresh_busy_next = (state_next == S_RPRE) || (state_next == S_REF);
        done_next         = (state_reg == S_COL) && ack;
        cmd_next          = CMD_ACT;
        cmd_bank_next     = '0;
        cmd_row_next      = '0;
        cmd_col_next      = '0;
        cmd_rw_next       = 1'b0;

        case (state_next)
            S_PRE: begin
                cmd_next      = CMD_PRE;
                cmd_bank_next = bank_next;
            end
            S_ACT: begin
                cmd_next      = CMD_ACT;
                cmd_bank_next = bank_next;
                cmd_row_next  = row_next;
            end
            S_COL: begin
                cmd_next      = CMD_COL;
                cmd_bank_next = bank_next;
                cmd_col_next  = col_next;
                cmd_rw_next   = rw_next;
            end
            S_RPRE: begin
                cmd_next      = CMD_PRE;
                cmd_bank_next = lowest_open(bank_open_next);
            end
            S_REF: begin
                cmd_next      = CMD_REF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            req_rdy_reg      <= 1'b0;
            cmd_req_reg      <= 1'b0;
            cmd_reg          <= 2'b00;
            cmd_bank_reg     <= '0;
            cmd_row_reg      <= '0;
            cmd_col_reg      <= '0;
            cmd_rw_reg       <= 1'b0;
            done_reg         <= 1'b0;
            refresh_busy_reg <= 1'b0;
        end else begin
            req_rdy_reg      <= req_rdy_next;
            cmd_req_reg      <= cmd_req_next;
            cmd_reg          <= cmd_next;
            cmd_bank_reg     <= cmd_bank_next;
            cmd_row_reg      <= cmd_row_next;
            cmd_col_reg      <= cmd_col_next;
            cmd_rw_reg       <= cmd_rw_next;
            done_reg         <= done_next;
            refresh_busy_reg <= refresh_busy_next;
        end
    end

    assign req_rdy      = req_rdy_reg;
    assign cmd_req      = cmd_req_reg;
    assign cmd          = cmd_reg;
    assign cmd_bank     = cmd_bank_reg;
    assign cmd_row      = cmd_row_reg;
    assign cmd_col      = cmd_col_reg;
    assign cmd_rw       = cmd_rw_reg;
    assign done         = done_reg;
    assign bank_open    = bank_open_reg;
    assign refresh_busy = refresh_busy_reg;
    assign refresh_miss = refresh_miss_reg;

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Bench for dram_bank_scheduler: directed scenarios plus random requests, checked against
// a transaction-level model of open pages, command sequences and refresh timing.
module tb_dram_bank_scheduler;

    localparam int NB = 8;
    localparam int NR = 128;
    localparam int NC = 8;
    localparam int RI = 64;
    localparam int BW = 3;
    localparam int RW = 7;
    localparam int CW = 3;

    localparam logic [1:0] C_ACT = 2'b00;
    localparam logic [1:0] C_COL = 2'b01;
    localparam logic [1:0] C_PRE = 2'b10;
    localparam logic [1:0] C_REF = 2'b11;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          req_val = 1'b0;
    logic          req_rw = 1'b0;
    logic [BW-1:0] req_bank = '0;
    logic [RW-1:0] req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic          req_rdy;
    logic          cmd_req;
    logic [1:0]    cmd;
    logic [BW-1:0] cmd_bank;
    logic [RW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic          cmd_rw;
    logic          cmd_ack = 1'b0;
    logic          done;
    logic [NB-1:0] bank_open;
    logic          refresh_busy;
    logic          refresh_miss;

    always #5 clk = ~clk;

    dram_bank_scheduler #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .req_val(req_val), .req_rw(req_rw), .req_bank(req_bank), .req_row(req_row),
        .req_col(req_col), .req_rdy(req_rdy),
        .cmd_req(cmd_req), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .cmd_rw(cmd_rw), .cmd_ack(cmd_ack),
        .done(done), .bank_open(bank_open),
        .refresh_busy(refresh_busy), .refresh_miss(refresh_miss)
    );

    int total = 0;
    int bad = 0;
    int edges = 0;
    int last_done_edge = -1;
    int n_req = 0;
    bit m_pending = 1'b0;
    bit m_miss = 1'b0;
    bit m_open [NB];
    int m_row [NB];
    bit col_flag = 1'b0;
    bit ref_flag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    function automatic logic [NB-1:0] open_vec();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = m_open[b];
        return v;
    endfunction

    function automatic logic [31:0] pack_cmd(input logic [1:0] c, input int b, input int r,
                                             input int col, input bit rw, input bit busy);
        return 32'({1'b0, 1'b1, c, BW'(b), RW'(r), CW'(col), rw, busy});
    endfunction

    function automatic logic [31:0] obs_cmd();
        return 32'({req_rdy, cmd_req, cmd, cmd_bank, cmd_row, cmd_col, cmd_rw, refresh_busy});
    endfunction

    function automatic logic [31:0] obs_all();
        return 32'({req_rdy, cmd_req, cmd, cmd_bank, cmd_row, cmd_col, cmd_rw, done,
                    bank_open, refresh_busy, refresh_miss});
    endfunction

    // One clock: advance the refresh-interval model and check done / refresh_miss.
    task automatic tick();
        bit rst_hi;
        bit exp_done;
        rst_hi   = rst_b;
        exp_done = col_flag && rst_hi;
        @(posedge clk);
        #1;
        if (rst_hi) begin
            edges++;
            if (ref_flag) m_pending = 1'b0;
            if (edges % RI == 0) begin
                if (m_pending) m_miss = 1'b1;
                m_pending = 1'b1;
            end
        end else begin
            edges = 0;
            m_pending = 1'b0;
            m_miss = 1'b0;
            foreach (m_open[i]) m_open[i] = 1'b0;
        end
        chk("done", 32'(done), 32'(exp_done));
        if (done) last_done_edge = edges;
        chk("refresh_miss", 32'(refresh_miss), 32'(m_miss));
        col_flag = 1'b0;
        ref_flag = 1'b0;
    endtask

    // Expect a command to be presented now; hold it for `stall` cycles, then ack it.
    task automatic serve_cmd(input string tag, input logic [1:0] c, input int b, input int r,
                             input int col, input bit rw, input bit busy, input int stall);
        for (int s = 0; s <= stall; s++) begin
            chk(tag, obs_cmd(), pack_cmd(c, b, r, col, rw, busy));
            if (s == stall) begin
                cmd_ack  = 1'b1;
                col_flag = (c == C_COL);
                ref_flag = (c == C_REF);
            end
            tick();
            cmd_ack = 1'b0;
        end
    endtask

    task automatic serve_refresh(input int ref_stall);
        int waited;
        waited = 0;
        while (!cmd_req && waited < 3) begin
            chk("rdy_while_pending", 32'(req_rdy), 32'd0);
            tick();
            waited++;
        end
        for (int b = 0; b < NB; b++) begin
            if (m_open[b]) begin
                serve_cmd("rpre", C_PRE, b, 0, 0, 1'b0, 1'b1, 0);
                m_open[b] = 1'b0;
            end
        end
        serve_cmd("ref", C_REF, 0, 0, 0, 1'b0, 1'b1, ref_stall);
        chk("bank_open_after_ref", 32'(bank_open), 32'd0);
        chk("busy_after_ref", 32'(refresh_busy), 32'd0);
        chk("rdy_after_ref", 32'(req_rdy), 32'(!m_pending));
        $display("refresh at edge %0d: ref_stall=%0d miss=%0d", edges, ref_stall, refresh_miss);
    endtask

    task automatic do_req(input bit rw, input int b, input int r, input int c,
                          input int st0, input int st1, input int st2, input bit abort);
        int t_acc;
        int ncmd;
        int stc;
        int exp_lat;
        string kind;
        for (int g = 0; g < 4 && m_pending; g++) serve_refresh(int'($urandom_range(0, 2)));
        chk("rdy_before_req", 32'(req_rdy), 32'd1);
        req_val  = 1'b1;
        req_rw   = rw;
        req_bank = BW'(b);
        req_row  = RW'(r);
        req_col  = CW'(c);
        tick();
        req_val = 1'b0;
        t_acc = edges;
        last_done_edge = -1;
        chk("rdy_after_accept", 32'(req_rdy), 32'd0);
        if (m_open[b] && m_row[b] == r) begin
            kind = "hit";
            ncmd = 1;
            stc = st0;
            exp_lat = 2 + st0;
        end else if (m_open[b]) begin
            kind = "conflict";
            ncmd = 3;
            stc = st2;
            exp_lat = 4 + st0 + st1 + st2;
            serve_cmd("pre", C_PRE, b, 0, 0, 1'b0, 1'b0, st0);
        end else begin
            kind = "closed";
            ncmd = 2;
            stc = st1;
            exp_lat = 3 + st0 + st1;
        end
        if (ncmd > 1) serve_cmd("act", C_ACT, b, r, 0, 1'b0, 1'b0, (ncmd == 3) ? st1 : st0);
        m_open[b] = 1'b1;
        m_row[b]  = r;
        if (abort) begin
            chk("col_before_reset", obs_cmd(), pack_cmd(C_COL, b, 0, c, rw, 1'b0));
            rst_b = 1'b0;
            tick();
            chk("outputs_after_midop_reset", obs_all(), 32'd0);
            rst_b = 1'b1;
            tick();
            chk("rdy_after_reset_release", 32'(req_rdy), 32'd1);
            $display("req %0d: %s b=%0d r=%0d aborted by reset", n_req, kind, b, r);
        end else begin
            serve_cmd("col", C_COL, b, 0, c, rw, 1'b0, stc);
            chk("done_latency", 32'(last_done_edge + 1 - t_acc), 32'(exp_lat));
            chk("bank_open", 32'(bank_open), 32'(open_vec()));
            chk("rdy_after_done", 32'(req_rdy), 32'(!m_pending));
            $display("req %0d: %s rw=%0d b=%0d r=%0d c=%0d latency=%0d", n_req, kind, rw, b, r, c,
                     last_done_edge + 1 - t_acc);
        end
        n_req++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (m_open[i]) begin
            m_open[i] = 1'b0;
            m_row[i] = 0;
        end

        // Reset: everything zero, req_rdy rises on the first released edge.
        rst_b = 1'b0;
        tick();
        tick();
        chk("outputs_in_reset", obs_all(), 32'd0);
        rst_b = 1'b1;
        tick();
        chk("rdy_first_edge", 32'(req_rdy), 32'd1);

        // Closed bank, page hit, conflict, then hit on the newly opened row.
        do_req(1'b0, 2, 5, 3, 0, 0, 0, 1'b0);
        chk("bank_open_b2", 32'(bank_open), 32'h04);
        do_req(1'b1, 2, 5, 1, 0, 0, 0, 1'b0);
        do_req(1'b0, 2, 9, 4, 0, 0, 0, 1'b0);
        do_req(1'b0, 2, 9, 0, 0, 0, 0, 1'b0);

        // ACT stalled five cycles, then a stray ack while idle.
        do_req(1'b0, 3, 7, 2, 5, 0, 0, 1'b0);
        for (int g = 0; g < 4 && m_pending; g++) serve_refresh(0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        chk("stray_ack_cmd_req", 32'(cmd_req), 32'd0);
        chk("stray_ack_bank_open", 32'(bank_open), 32'(open_vec()));

        // Refresh with open banks.
        do_req(1'b0, 1, 11, 0, 0, 1, 0, 1'b0);
        do_req(1'b1, 6, 20, 7, 1, 0, 0, 1'b0);
        for (int i = 0; i < RI + 2 && !m_pending; i++) tick();
        serve_refresh(0);

        // Request raised while a refresh is pending waits for the REF ack.
        do_req(1'b0, 4, 3, 1, 0, 0, 0, 1'b0);
        for (int i = 0; i < RI + 2 && !m_pending; i++) tick();
        req_val  = 1'b1;
        req_rw   = 1'b1;
        req_bank = BW'(5);
        req_row  = RW'(3);
        req_col  = CW'(6);
        do_req(1'b1, 5, 3, 6, 0, 0, 0, 1'b0);

        // Random traffic over a few rows per bank to mix hits, conflicts and closed banks.
        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, NC - 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 1'b0);
        end

        // REF ack held longer than a full interval: sticky miss.
        for (int i = 0; i < RI + 2 && !m_pending; i++) tick();
        serve_refresh(RI + 6);
        chk("refresh_miss_set", 32'(refresh_miss), 32'd1);
        tick();
        tick();
        chk("refresh_miss_sticky", 32'(refresh_miss), 32'd1);

        // Reset during COL aborts the sequence without a done pulse.
        do_req(1'b1, 0, 2, 5, 0, 0, 0, 1'b1);
        tick();
        chk("no_done_after_abort", 32'(done), 32'd0);
        chk("banks_closed_after_abort", 32'(bank_open), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
